// File: rtl/controle_modo.sv
// controle_modo -- control front-end for the seven-row message register bank.
//
// Cleans up a bouncy active-low push button, steps through four display modes
// on each accepted press, and divides the board clock into a one-cycle shift
// tick so the row registers scroll at a visible rate.
//
// Parameters:
//   DEB_CYCLES  cycles the synchronised button must differ from its stable
//               value before the change is accepted
//   TICK_DIV    clock cycles per shift tick (>= 2)
//   AUTO_TICKS  ticks between automatic mode advances (optional feature only)
//
// Ports:
//   clk      board clock, rising edge
//   rst_n    asynchronous active-low reset
//   btn_n    raw push button, low = pressed, asynchronous to clk
//   auto_sw  auto-advance enable (optional feature only)
//   ch0/ch1  mode bits to the register bank
//   tick     one-cycle shift enable
//   press    one-cycle pulse per accepted press
//
// Optional feature: define CONTROLE_MODO_AUTO_EN to add auto_sw and an
// automatic mode advance every AUTO_TICKS ticks.

module controle_modo #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned TICK_DIV   = 12500000
`ifdef CONTROLE_MODO_AUTO_EN
    ,
    parameter int unsigned AUTO_TICKS = 16
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
`ifdef CONTROLE_MODO_AUTO_EN
    input  logic auto_sw,
`endif
    output logic ch0,
    output logic ch1,
    output logic tick,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Synchroniser + debouncer
    // ------------------------------------------------------------------
    logic          sync1, sync2;
    logic          stable, stable_d;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            deb_cnt  <= '0;
        end else begin
            sync1    <= btn_n;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 != stable) begin
                // Accept the new level only after DEB_CYCLES consecutive
                // disagreeing samples; any agreeing sample restarts the count.
                if (deb_cnt == DEB_LAST) begin
                    stable  <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Falling edge of the debounced level only; release produces nothing.
    assign press = stable_d & ~stable;

    // ------------------------------------------------------------------
    // Prescaler / shift tick
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (press) begin
            // Restart the period so a new mode always gets a full first tick.
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + 1'b1;
            tick  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Mode advance source
    // ------------------------------------------------------------------
    logic advance;

`ifdef CONTROLE_MODO_AUTO_EN
    localparam int AW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_TICKS - 1);

    logic [AW-1:0] auto_cnt;
    logic          auto_adv;

    assign auto_adv = auto_sw & tick & (auto_cnt == AUTO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (press || !auto_sw) begin
            auto_cnt <= '0;
        end else if (tick) begin
            auto_cnt <= (auto_cnt == AUTO_LAST) ? '0 : auto_cnt + 1'b1;
        end
    end

    // A press and an auto advance in the same cycle still step only once.
    assign advance = press | auto_adv;
`else
    assign advance = press;
`endif

    // ------------------------------------------------------------------
    // Mode state machine
    // ------------------------------------------------------------------
    mode_t mode, mode_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode <= MODE0;
        else        mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode;
        if (advance) begin
            case (mode)
                MODE0:   mode_nxt = MODE1;
                MODE1:   mode_nxt = MODE2;
                MODE2:   mode_nxt = MODE3;
                default: mode_nxt = MODE0;
            endcase
        end
    end

    assign ch0 = mode[0];
    assign ch1 = mode[1];

endmodule

// File: tb/tb_controle_modo.sv
// Self-checking bench for controle_modo (DEB_CYCLES=4, TICK_DIV=5, AUTO_TICKS=3).
// Directed scenarios plus a random button stream, checked every cycle against
// an event-level reference model (run lengths, modular tick timing, mode count).

module tb_controle_modo;

    localparam int DEB_CYCLES = 4;
    localparam int TICK_DIV   = 5;
    localparam int AUTO_TICKS = 3;

    logic clk, rst_n, btn_n, auto_sw;
    logic ch0, ch1, tick, press;

    controle_modo #(
        .DEB_CYCLES(DEB_CYCLES),
        .TICK_DIV  (TICK_DIV)
`ifdef CONTROLE_MODO_AUTO_EN
        ,
        .AUTO_TICKS(AUTO_TICKS)
`endif
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n  (btn_n),
`ifdef CONTROLE_MODO_AUTO_EN
        .auto_sw(auto_sw),
`endif
        .ch0    (ch0),
        .ch1    (ch1),
        .tick   (tick),
        .press  (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nasserts, nfails;

    // Reference model state
    int n, last_clear, m_mode, m_run, m_acnt;
    bit m_stab, m_tick, m_press;
    bit hist[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; last_clear = 0; m_mode = 0; m_run = 0; m_acnt = 0;
        m_stab = 1'b1; m_tick = 1'b0; m_press = 1'b0;
        hist.delete();
        hist.push_back(1'b1);
        hist.push_back(1'b1);
    endtask

    // One rising edge of the model. b/a are the input levels seen by that edge.
    task automatic model_edge(input bit b, input bit a);
        bit pr, tk, seen, old;
        pr = m_press;
        tk = m_tick;
        n++;
        if (pr) begin
            m_mode = (m_mode + 1) % 4;
            last_clear = n;
            m_tick = 1'b0;
        end else begin
            m_tick = ((n - last_clear) % TICK_DIV) == 0;
        end
        if (pr || !a) m_acnt = 0;
        else if (tk) begin
            if (m_acnt == AUTO_TICKS - 1) begin
                m_mode = (m_mode + 1) % 4;
                m_acnt = 0;
            end else m_acnt++;
        end
        // The debouncer sees the button two edges late.
        seen = hist.pop_front();
        hist.push_back(b);
        old = m_stab;
        if (seen != m_stab) begin
            m_run++;
            if (m_run == DEB_CYCLES) begin
                m_stab = seen;
                m_run = 0;
            end
        end else m_run = 0;
        m_press = old & ~m_stab;
    endtask

    task automatic step();
        bit b, a;
        b = btn_n;
`ifdef CONTROLE_MODO_AUTO_EN
        a = auto_sw;
`else
        a = 1'b0;
`endif
        @(posedge clk);
        model_edge(b, a);
        #1;
        chk("mode",  8'({ch1, ch0}), 8'(m_mode));
        chk("tick",  8'(tick),       8'(m_tick));
        chk("press", 8'(press),      8'(m_press));
    endtask

    task automatic do_reset();
        btn_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mode",  8'({ch1, ch0}), 8'd0);
        chk("rst_tick",  8'(tick),       8'd0);
        chk("rst_press", 8'(press),      8'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    int npress;
    logic [1:0] exp_modes [4];

    initial begin
        nasserts = 0; nfails = 0;
        btn_n = 1'b1; rst_n = 1'b0; auto_sw = 1'b0;
        model_reset();
        exp_modes[0] = 2'b01; exp_modes[1] = 2'b10;
        exp_modes[2] = 2'b11; exp_modes[3] = 2'b00;

        // Reset and free-running tick cadence
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("tick_cadence", 8'(tick), 8'((i % 5) == 0));
        end

        // Tick must drop immediately on a mid-operation reset
        do_reset();
        for (int i = 1; i <= 5; i++) step();
        chk("tick_before_rst", 8'(tick), 8'd1);
        do_reset();

        // Clean press: one press, mode 01 at edge 7, nothing on release
        npress = 0;
        btn_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (press) npress++;
            if (i == 6) chk("clean_e6", 8'({ch1, ch0}), 8'd0);
            if (i == 7) chk("clean_e7", 8'({ch1, ch0}), 8'd1);
        end
        btn_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (press) npress++;
        end
        chk("clean_count", 8'(npress), 8'd1);
        chk("clean_release", 8'({ch1, ch0}), 8'd1);

        // Bounce shorter than the debounce window, then four clean presses
        do_reset();
        btn_n = 1'b0; for (int i = 0; i < 3; i++) step();
        btn_n = 1'b1; step();
        btn_n = 1'b0; for (int i = 0; i < 3; i++) step();
        btn_n = 1'b1; for (int i = 0; i < 10; i++) step();
        chk("bounce_mode", 8'({ch1, ch0}), 8'd0);
        for (int p = 0; p < 4; p++) begin
            btn_n = 1'b0; for (int i = 0; i < 10; i++) step();
            btn_n = 1'b1; for (int i = 0; i < 10; i++) step();
            chk("press_seq", 8'({ch1, ch0}), 8'(exp_modes[p]));
        end

        // Press landing on terminal count: mode changes at edge 10
        do_reset();
        for (int i = 0; i < 3; i++) step();
        btn_n = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("term_mode", 8'({ch1, ch0}), 8'd1);
        chk("term_tick", 8'(tick), 8'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("term_gap", 8'(tick), 8'd0);
        end
        step();
        chk("term_next", 8'(tick), 8'd1);
        btn_n = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Reset in the middle of a debounce count
        do_reset();
        btn_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        do_reset();
        npress = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (press) npress++;
        end
        chk("middeb_press", 8'(npress), 8'd0);
        chk("middeb_mode", 8'({ch1, ch0}), 8'd0);
        btn_n = 1'b0; for (int i = 0; i < 12; i++) step();
        btn_n = 1'b1; for (int i = 0; i < 4; i++) step();
        chk("middeb_after", 8'({ch1, ch0}), 8'd1);

`ifdef CONTROLE_MODO_AUTO_EN
        // Auto advance every 15 cycles
        do_reset();
        auto_sw = 1'b1;
        for (int i = 1; i <= 61; i++) begin
            step();
            if (i == 16) chk("auto_1", 8'({ch1, ch0}), 8'd1);
            if (i == 31) chk("auto_2", 8'({ch1, ch0}), 8'd2);
            if (i == 46) chk("auto_3", 8'({ch1, ch0}), 8'd3);
            if (i == 61) chk("auto_0", 8'({ch1, ch0}), 8'd0);
        end
        // Press coinciding with an auto advance at edge 16
        do_reset();
        auto_sw = 1'b1;
        for (int i = 1; i <= 9; i++) step();
        btn_n = 1'b0;
        for (int i = 10; i <= 16; i++) step();
        chk("auto_press", 8'({ch1, ch0}), 8'd1);
        btn_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        auto_sw = 1'b0;
`endif

        // Random button stream (and auto switch when present)
        do_reset();
        for (int r = 0; r < 60; r++) begin
            int len;
            btn_n = 1'($urandom_range(0, 1));
            auto_sw = ($urandom_range(0, 3) != 0);
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) step();
        end
        btn_n = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
        $finish;
    end

endmodule
